// File: rtl/antirrebote_boton.sv
// antirrebote_boton: debounces one raw push-button pin into a clean level plus press/release strobes
//
// Ports:
//   clk         in   system clock, all state updates on its rising edge
//   rst_n       in   synchronous reset, active-low
//   btn_in      in   raw asynchronous bouncing button pin, active-high
//   btn_level   out  debounced button state, 1 = pressed
//   btn_pulse   out  one-cycle strobe per accepted press (and per auto-repeat when enabled)
//   btn_release out  one-cycle strobe per accepted release
//
// Build option: define ANTIRREBOTE_AUTOREPEAT_EN to emit auto-repeat pulses while the
// button stays held (first after REPEAT_DELAY cycles, then every REPEAT_RATE cycles).
module antirrebote_boton #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_RATE     = 10_000_000,
    parameter int unsigned REP_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;

`ifdef ANTIRREBOTE_AUTOREPEAT_EN
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             first_q, first_d;
    logic             rep_hit;

    // The first repeat waits the long delay, later ones use the shorter rate.
    assign rep_hit = first_q ? (rep_q == REP_DELAY_LAST) : (rep_q == REP_RATE_LAST);
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_RATE, REP_W};
`endif

    always_comb begin
        s1_d      = btn_in;
        s2_d      = s1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
        rep_d     = rep_q;
        first_d   = first_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = s2_q ? PRESS_WAIT : IDLE;
                cnt_d   = s2_q ? CNT_W'(1) : '0;
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
                    rep_d   = '0;
                    first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
                else if (rep_hit) begin
                    pulse_d = 1'b1;
                    rep_d   = '0;
                    first_d = 1'b0;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                // A bounce back to 1 returns to PRESSED silently; rep keeps its count.
                if (s2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
            rep_q     <= '0;
            first_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
            rep_q     <= rep_d;
            first_q   <= first_d;
`endif
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_antirrebote_boton.sv
// tb_antirrebote_boton: directed table plus hand sequences for the button debouncer (D=4)
module tb_antirrebote_boton;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, btn_pulse, btn_release;

    int passed = 0;
    int total  = 0;

`ifdef ANTIRREBOTE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    antirrebote_boton #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE(3),
        .REP_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Inputs applied at this edge, outputs expected right after it.
    typedef struct packed {
        logic rst_n;
        logic btn;
        logic lvl;
        logic pul;
        logic rel;
    } vec_t;

    vec_t tbl [40];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic step(input logic r, input logic b);
        rst_n  = r;
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic l, input logic p, input logic r);
        chk({nm, " level"}, {7'd0, btn_level}, {7'd0, l});
        chk({nm, " pulse"}, {7'd0, btn_pulse}, {7'd0, p});
        chk({nm, " release"}, {7'd0, btn_release}, {7'd0, r});
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tbl[i] = 5'b01000;
        for (int i = 3; i < 8; i++) tbl[i] = 5'b11000;
        tbl[8] = 5'b11110;
        tbl[9] = 5'b11100;
        tbl[10] = 5'b11100;
        tbl[11] = 5'b10100;
        tbl[12] = 5'b10100;
        tbl[13] = 5'b11100;
        for (int i = 14; i < 19; i++) tbl[i] = 5'b10100;
        tbl[19] = 5'b10001;
        tbl[20] = 5'b10000;
        for (int i = 21; i < 24; i++) tbl[i] = 5'b11000;
        tbl[24] = 5'b10000;
        for (int i = 25; i < 30; i++) tbl[i] = 5'b11000;
        tbl[30] = 5'b11110;
        tbl[31] = 5'b11100;
        tbl[32] = 5'b11100;
        for (int i = 33; i < 38; i++) tbl[i] = 5'b10100;
        tbl[38] = 5'b10001;
        tbl[39] = 5'b10000;

        // Reset with button held, press, release glitch, bounce reject, clean release.
        for (int i = 0; i < 40; i++) begin
            step(tbl[i].rst_n, tbl[i].btn);
            chk_out($sformatf("row%0d", i), tbl[i].lvl, tbl[i].pul, tbl[i].rel);
        end

        // Long hold: one pulse at 5, auto-repeat at 15,18,...; release accepted at 35.
        for (int k = 0; k < 40; k++) begin
            logic ep;
            ep = (k == 5) || (AR && k >= 15 && k <= 30 && (k - 15) % 3 == 0);
            step(1'b1, k < 30);
            chk_out($sformatf("hold%0d", k), k >= 5 && k < 35, ep, k == 35);
        end

        // Reset during PRESS_WAIT with cnt=2.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
        chk("pw cnt before reset", 8'(dut.cnt_q), 8'd2);
        step(1'b0, 1'b1);
        chk_out("pw reset", 1'b0, 1'b0, 1'b0);
        chk("pw reset state", 8'(dut.state_q), 8'd0);
        chk("pw reset cnt", 8'(dut.cnt_q), 8'd0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            chk_out($sformatf("pw after%0d", k), 1'b0, 1'b0, 1'b0);
        end

        // Reset while PRESSED: outputs clear, no release strobe afterwards.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1);
        chk_out("pressed before reset", 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk_out("pressed reset", 1'b0, 1'b0, 1'b0);
        chk("pressed reset state", 8'(dut.state_q), 8'd0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            chk_out($sformatf("pr after%0d", k), 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/antirrebote_boton.md
# antirrebote_boton

- Debounces one raw push-button pin and converts it into clean, clock-synchronous events.
- Sits directly upstream of the button controller:
  - `btn_pulse` drives that controller's button-set input, so a bouncing contact produces exactly one set event per press.
  - `btn_level` stays available to the I/O map as a clean, filtered level.
- One instance per board button.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive identical synchronized samples required to accept a level change. Legal range is 2 to 2^CNT_W−1.
- `CNT_W`, default 20: width of the debounce counter.
- `REPEAT_DELAY`, default 50_000_000: cycles from the press pulse to the first auto-repeat pulse. Auto-repeat builds only; legal range is 1 to 2^REP_W−1.
- `REPEAT_RATE`, default 10_000_000: cycles between subsequent auto-repeat pulses. Auto-repeat builds only; legal range is 1 to 2^REP_W−1.
- `REP_W`, default 26: width of the repeat counter.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `btn_in`  in  1  raw, asynchronous, bouncing button pin, active-high.
- `btn_level`  out  1  debounced button state; 1 = pressed.
- `btn_pulse`  out  1  one-cycle strobe on each accepted press, and on each auto-repeat when that feature is enabled.
- `btn_release`  out  1  one-cycle strobe on each accepted release.

## Operation

- **Synchronizer:** `btn_in` passes through a two-flop synchronizer, `s1` then `s2`. The FSM uses only `s2`.
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- **IDLE:**
  - `s2`=1 → PRESS_WAIT, `cnt`←1.
  - Otherwise stay in IDLE, `cnt`←0.
- **PRESS_WAIT:**
  - `s2`=0 → IDLE, `cnt`←0. This is a glitch: no outputs.
  - `s2`=1 and `cnt`=DEBOUNCE_CYCLES−1 → PRESSED. `btn_level`←1, `btn_pulse`←1, `rep`←0, `first`←1.
  - Otherwise `cnt`←`cnt`+1.
- **PRESSED:**
  - `s2`=0 → RELEASE_WAIT, `cnt`←1.
  - Otherwise the auto-repeat logic runs, if compiled in.
- **RELEASE_WAIT:**
  - `s2`=1 → PRESSED, `cnt`←0. This is a release glitch: `btn_level` stays 1 and no pulse is issued.
  - `s2`=0 and `cnt`=DEBOUNCE_CYCLES−1 → IDLE. `btn_level`←0, `btn_release`←1.
  - Otherwise `cnt`←`cnt`+1.
- **Strobes:**
  - `btn_pulse` and `btn_release` are registered.
  - Each defaults to 0 every cycle unless set by a transition above, so each is high for exactly one cycle.
- **Counters:**
  - `cnt` is unsigned CNT_W bits.
  - `cnt` never exceeds DEBOUNCE_CYCLES−1, so it cannot wrap.
- **Reset:**
  - `rst_n`=0 at an edge forces state IDLE, and `s1`, `s2`, `cnt`, `rep`, `first` to 0.
  - All outputs are forced to 0: `btn_level`, `btn_pulse`, `btn_release`.
  - Reset overrides every other condition, including when asserted mid-debounce or while pressed.
  - A button held through reset deassertion is treated as a new press and debounced from scratch.

## Timing

- Edge E0 is the first edge at which `btn_in`=1 is sampled into `s1`.
- If `btn_in` is 1 at edges E0 through E(D−1), where D = DEBOUNCE_CYCLES:
  - `btn_level` and `btn_pulse` become 1 after edge E(D+1). Latency is D+1 cycles.
  - `btn_pulse` returns to 0 after edge E(D+2).
- Release is symmetric: `btn_level` falls and `btn_release` pulses D+1 cycles after the first sampled 0.
- Fewer than D consecutive identical samples never changes `btn_level`.
- No output changes during reset.
- `btn_pulse` and `btn_release` never assert in the same cycle.

## Configuration

Macro `ANTIRREBOTE_AUTOREPEAT_EN`:
- **Defined:**
  - While in PRESSED, `rep` increments each cycle.
  - When `first`=1 and `rep`=REPEAT_DELAY−1, or `first`=0 and `rep`=REPEAT_RATE−1: `btn_pulse`←1, `rep`←0, `first`←0.
  - In RELEASE_WAIT, `rep` holds its value, and counting resumes if the FSM returns to PRESSED.
- **Undefined:**
  - The `rep` and `first` registers and the REPEAT_DELAY, REPEAT_RATE and REP_W parameters are not used.
  - Exactly one `btn_pulse` is issued per accepted press.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles with `btn_in`=1 → all outputs 0 and state IDLE. After release, with D=4, `btn_pulse` fires 5 cycles after the first sample.
- **Clean press:** D=4, `btn_in` 0→1 and held → `btn_level`=1 and a single 1-cycle `btn_pulse` exactly 5 cycles after E0. No further pulses with the macro undefined.
- **Bounce reject:** D=4, `btn_in` high for 3 samples, low for 1, then high steadily → no pulse from the bounce; exactly one pulse 5 cycles after the final rising sample.
- **Release:**
  - D=4, press accepted, then `btn_in` low for 2 samples, high for 1, then low steadily → `btn_level` stays 1 through the glitch.
  - `btn_level` falls and `btn_release` pulses once, 5 cycles after the final falling sample.
- **Auto-repeat** (macro defined, D=4, REPEAT_DELAY=10, REPEAT_RATE=3, held) → `btn_pulse` at press time T, then at T+10, T+13, T+16, continuing until release.
- **Reset mid-operation:** assert `rst_n`=0 during PRESS_WAIT (`cnt`=2) and again during PRESSED → next cycle shows IDLE, `cnt`=0, all outputs 0, and no `btn_release` strobe.
